uart_rx: RTL and testbench

//  8N1 asynchronous serial receiver; companion to the uart transmitter on the CPU data bus.
//  Two-flop synchroniser, mid-bit sampling from an internal bit-period counter on clk, and a

---
 rtl/uart_rx_if.sv | 21 ++
 rtl/uart_rx.sv | 133 +++++++++++++
 tb/tb_uart_rx.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receiver-side CPU/line signals for uart_rx.
// The slave modport is the receiver itself; the master modport is the line driver and bus reader.
interface uart_rx_if;
    logic       rx;
    logic       re;
    logic       err_clr;
    logic [7:0] rdata;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    modport master (
        output rx, re, err_clr,
        input  rdata, rx_valid, frame_err, overrun
    );

    modport slave (
        input  rx, re, err_clr,
        output rdata, rx_valid, frame_err, overrun
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM, small receive FIFO
// with a registered head view and sticky framing/overrun status.
module uart_rx #(
    parameter int unsigned BAUD_DIV   = 27,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic     clk,
    input logic     reset,
    uart_rx_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    sh, sh_n;
    logic          rx_m, rx_s;
    logic          push, fe_set;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, wr_n, rd_n;
    logic [7:0]    rdata_q, head_n;
    logic          rx_valid_q, frame_err_q, overrun_q;
    logic          pop, full, do_write, ovr_set;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
        end else begin
            rx_m    <= bus.rx;
            rx_s    <= rx_m;
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            sh      <= sh_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        sh_n    = sh;
        push    = 1'b0;
        fe_set  = 1'b0;
        if (cnt != '0) cnt_n = cnt - 1'b1;
        case (state)
            IDLE: if (!rx_s) begin
                state_n = START;
                cnt_n   = HALF_LOAD;
            end
            START: if (cnt == '0) begin
                if (!rx_s) begin
                    state_n = DATA;
                    cnt_n   = FULL_LOAD;
                    bit_n   = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            DATA: if (cnt == '0) begin
                sh_n[bit_idx] = rx_s;
                cnt_n         = FULL_LOAD;
                if (bit_idx == 3'd7) state_n = STOP;
                else                 bit_n   = bit_idx + 3'd1;
            end
            STOP: if (cnt == '0) begin
                if (rx_s) begin
                    push    = 1'b1;
                    state_n = IDLE;
                end else begin
                    fe_set  = 1'b1;
                    state_n = BRK;
                end
            end
            BRK: if (rx_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Head register is loaded with the post-edge head, bypassing the byte being written
    // when it lands in the slot that becomes the head.
    always_comb begin
        pop      = bus.re && rx_valid_q;
        full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        do_write = push && (!full || pop);
        ovr_set  = push && full && !pop;
        wr_n     = wr_ptr + (AW + 1)'(do_write);
        rd_n     = rd_ptr + (AW + 1)'(pop);
        head_n   = '0;
        if (wr_n != rd_n) begin
            if (do_write && rd_n == wr_ptr) head_n = sh;
            else                            head_n = mem[rd_n[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr[AW-1:0]] <= sh;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rdata_q     <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            wr_ptr      <= wr_n;
            rd_ptr      <= rd_n;
            rdata_q     <= head_n;
            rx_valid_q  <= (wr_n != rd_n);
            frame_err_q <= fe_set  ? 1'b1 : (bus.err_clr ? 1'b0 : frame_err_q);
            overrun_q   <= ovr_set ? 1'b1 : (bus.err_clr ? 1'b0 : overrun_q);
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven bit by bit, outputs checked on the falling clock edge.
module tb_uart_rx;
    localparam int unsigned BAUD = 27;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    uart_rx_if bus ();

    uart_rx #(.BAUD_DIV(BAUD), .FIFO_DEPTH(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        bus.rx = v;
        repeat (BAUD) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        bus.rx = 1'b1;
        repeat (n * BAUD) @(negedge clk);
    endtask

    // pop_at_push raises re for the single cycle whose rising edge samples the stop bit
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic pop_at_push);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        bus.rx = stop;
        for (int i = 0; i < int'(BAUD); i++) begin
            bus.re = pop_at_push && (i == 15);
            @(negedge clk);
        end
        bus.re = 1'b0;
    endtask

    task automatic pop_one();
        bus.re = 1'b1;
        @(negedge clk);
        bus.re = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_errs();
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        bus.rx      = 1'b1;
        bus.re      = 1'b0;
        bus.err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", {7'd0, bus.rx_valid}, 8'h00);
        check("reset_rdata", bus.rdata, 8'h00);
        check("reset_flags", {6'd0, bus.frame_err, bus.overrun}, 8'h00);
        reset = 1'b0;
        idle_bits(2);

        // single byte, then pop
        send_frame(8'h55, 1'b1, 1'b0);
        check("t1_valid", {7'd0, bus.rx_valid}, 8'h01);
        check("t1_rdata", bus.rdata, 8'h55);
        check("t1_flags", {6'd0, bus.frame_err, bus.overrun}, 8'h00);
        pop_one();
        check("t1_valid_pop", {7'd0, bus.rx_valid}, 8'h00);
        check("t1_rdata_pop", bus.rdata, 8'h00);
        idle_bits(1);

        // back-to-back fill plus an overrunning fifth byte
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        check("t2_overrun_pre", {7'd0, bus.overrun}, 8'h00);
        send_frame(8'h11, 1'b1, 1'b0);
        idle_bits(1);
        check("t2_overrun", {7'd0, bus.overrun}, 8'h01);
        check("t2_frame_err", {7'd0, bus.frame_err}, 8'h00);
        check("t2_rd0", bus.rdata, 8'h00); pop_one();
        check("t2_rd1", bus.rdata, 8'hFF); pop_one();
        check("t2_rd2", bus.rdata, 8'hA5); pop_one();
        check("t2_rd3", bus.rdata, 8'h3C);
        check("t2_valid3", {7'd0, bus.rx_valid}, 8'h01); pop_one();
        check("t2_empty", {7'd0, bus.rx_valid}, 8'h00);
        check("t2_empty_rdata", bus.rdata, 8'h00);
        pop_one();
        check("t2_empty_pop", {7'd0, bus.rx_valid}, 8'h00);
        clear_errs();
        check("t2_overrun_clr", {7'd0, bus.overrun}, 8'h00);

        // full FIFO with pop on the push cycle
        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'h02, 1'b1, 1'b0);
        send_frame(8'h03, 1'b1, 1'b0);
        send_frame(8'h04, 1'b1, 1'b0);
        send_frame(8'h77, 1'b1, 1'b1);
        idle_bits(1);
        check("t3_overrun", {7'd0, bus.overrun}, 8'h00);
        check("t3_rd0", bus.rdata, 8'h02); pop_one();
        check("t3_rd1", bus.rdata, 8'h03); pop_one();
        check("t3_rd2", bus.rdata, 8'h04); pop_one();
        check("t3_rd3", bus.rdata, 8'h77); pop_one();
        check("t3_empty", {7'd0, bus.rx_valid}, 8'h00);

        // bad stop bit followed by a long break
        send_frame(8'h81, 1'b0, 1'b0);
        repeat (2 * BAUD) @(negedge clk);
        check("t4_frame_err", {7'd0, bus.frame_err}, 8'h01);
        check("t4_no_push", {7'd0, bus.rx_valid}, 8'h00);
        clear_errs();
        check("t4_clr", {7'd0, bus.frame_err}, 8'h00);
        repeat (18 * BAUD) @(negedge clk);
        idle_bits(2);
        check("t4_single_err", {7'd0, bus.frame_err}, 8'h00);
        check("t4_no_push2", {7'd0, bus.rx_valid}, 8'h00);
        send_frame(8'h42, 1'b1, 1'b0);
        check("t4_good_valid", {7'd0, bus.rx_valid}, 8'h01);
        check("t4_good_rdata", bus.rdata, 8'h42);
        check("t4_good_flags", {6'd0, bus.frame_err, bus.overrun}, 8'h00);
        pop_one();

        // start-bit glitch
        bus.rx = 1'b0;
        repeat (BAUD / 4) @(negedge clk);
        idle_bits(3);
        check("t5_no_push", {7'd0, bus.rx_valid}, 8'h00);
        check("t5_flags", {6'd0, bus.frame_err, bus.overrun}, 8'h00);

        // reset mid-frame with two bytes queued
        send_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h34, 1'b1, 1'b0);
        check("t6_queued", bus.rdata, 8'h12);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        bus.rx = 1'b1;
        repeat (13) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_valid", {7'd0, bus.rx_valid}, 8'h00);
        check("t6_rst_rdata", bus.rdata, 8'h00);
        check("t6_rst_flags", {6'd0, bus.frame_err, bus.overrun}, 8'h00);
        reset = 1'b0;
        idle_bits(2);
        check("t6_idle_empty", {7'd0, bus.rx_valid}, 8'h00);
        send_frame(8'h99, 1'b1, 1'b0);
        check("t6_valid", {7'd0, bus.rx_valid}, 8'h01);
        check("t6_rdata", bus.rdata, 8'h99);
        pop_one();
        check("t6_empty", {7'd0, bus.rx_valid}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
